// File: rtl/prbs_check_pkg.sv
// Shared definitions for the PRBS7 checker back end: state encoding,
// word width and the clamp applied to per-word error popcounts.
package prbs_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HUNT   = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    localparam int WORD_BITS = 64;
    localparam logic [6:0] CLAMP_MAX = 7'd64;

    // A 64-bit word cannot hold more than 64 error bits.
    function automatic logic [6:0] clamp_cnt(input logic [6:0] v);
        return (v > CLAMP_MAX) ? CLAMP_MAX : v;
    endfunction

endpackage

// File: rtl/sat_accum.sv
// Saturating accumulator with synchronous clear; holds all-ones once full.
// Clear wins over enable.
module sat_accum #(
    parameter int W  = 48,
    parameter int IW = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic [IW-1:0] inc,
    output logic [W-1:0]  q
);

    logic [W:0] sum;

    assign sum = {1'b0, q} + (W+1)'(inc);

    // Add increment, clamping at all-ones on carry out.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (en) begin
            q <= sum[W] ? '1 : sum[W-1:0];
        end
    end

endmodule

// File: rtl/prbs7_error_accumulator.sv
// Lock hunting and error accumulation behind the PRBS7 checker.
// Define PRBS_ERR_USER_COUNT_EN to build the user-error accumulator.
module prbs7_error_accumulator
    import prbs_check_pkg::*;
#(
    parameter int CNT_W         = 48,
    parameter int SETTLE_CYCLES = 8,
    parameter int LOCK_WORDS    = 16,
    parameter int UNLOCK_THRESH = 16,
    parameter int UNLOCK_WORDS  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [6:0]       errorCounter,
    input  logic [6:0]       usererrorCounter,
    input  logic             snapReq,
    output logic [1:0]       state,
    output logic             locked,
    output logic [CNT_W-1:0] wordCount,
    output logic [CNT_W-1:0] errorBitCount,
    output logic [CNT_W-1:0] userErrorBitCount,
    output logic [15:0]      lolCount,
    output logic [CNT_W-1:0] snapWords,
    output logic [CNT_W-1:0] snapErrors,
    output logic [CNT_W-1:0] snapUserErrors,
    output logic [15:0]      snapLol,
    output logic             snapDone
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int GW = $clog2(LOCK_WORDS + 1);
    localparam int BW = $clog2(UNLOCK_WORDS + 1);

    state_t         state_q, state_d;
    logic [SW-1:0]  settle_q, settle_d;
    logic [GW-1:0]  good_q, good_d;
    logic [BW-1:0]  bad_q, bad_d;
    logic           acc_en;
    logic           lol_inc;
    logic [6:0]     e;

    assign e      = clamp_cnt(errorCounter);
    assign state  = state_q;
    assign locked = (state_q == ST_LOCKED);

    // State and run-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            good_q   <= '0;
            bad_q    <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
        end
    end

    // Next state, run counters and accumulate strobes.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        good_d   = good_q;
        bad_d    = bad_q;
        acc_en   = 1'b0;
        lol_inc  = 1'b0;
        if (start) begin
            state_d  = ST_SETTLE;
            settle_d = '0;
            good_d   = '0;
            bad_d    = '0;
        end else if (stop) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                end
                ST_SETTLE: begin
                    if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                        state_d = ST_HUNT;
                        good_d  = '0;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                ST_HUNT: begin
                    if (e == 7'd0) begin
                        if (good_q == GW'(LOCK_WORDS - 1)) begin
                            state_d = ST_LOCKED;
                            good_d  = '0;
                            bad_d   = '0;
                        end else begin
                            good_d = good_q + 1'b1;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                ST_LOCKED: begin
                    acc_en = 1'b1;
                    if (e >= 7'(UNLOCK_THRESH)) begin
                        if (bad_q == BW'(UNLOCK_WORDS - 1)) begin
                            state_d = ST_HUNT;
                            lol_inc = 1'b1;
                            bad_d   = '0;
                            good_d  = '0;
                        end else begin
                            bad_d = bad_q + 1'b1;
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    sat_accum #(.W(CNT_W), .IW(1)) u_words (
        .clk   (clk),
        .reset (reset),
        .clr   (start),
        .en    (acc_en),
        .inc   (1'b1),
        .q     (wordCount)
    );

    sat_accum #(.W(CNT_W), .IW(7)) u_errors (
        .clk   (clk),
        .reset (reset),
        .clr   (start),
        .en    (acc_en),
        .inc   (e),
        .q     (errorBitCount)
    );

    sat_accum #(.W(16), .IW(1)) u_lol (
        .clk   (clk),
        .reset (reset),
        .clr   (start),
        .en    (lol_inc),
        .inc   (1'b1),
        .q     (lolCount)
    );

`ifdef PRBS_ERR_USER_COUNT_EN
    logic [6:0] u;

    assign u = clamp_cnt(usererrorCounter);

    sat_accum #(.W(CNT_W), .IW(7)) u_user (
        .clk   (clk),
        .reset (reset),
        .clr   (start),
        .en    (acc_en),
        .inc   (u),
        .q     (userErrorBitCount)
    );

    // User-error snapshot, captured alongside the other totals.
    always_ff @(posedge clk) begin
        if (reset) begin
            snapUserErrors <= '0;
        end else if (snapReq) begin
            snapUserErrors <= userErrorBitCount;
        end
    end
`else
    logic unused_user;

    assign unused_user       = ^usererrorCounter;
    assign userErrorBitCount = '0;
    assign snapUserErrors    = '0;
`endif

    // Snapshot of pre-update totals, valid the cycle after the request.
    always_ff @(posedge clk) begin
        if (reset) begin
            snapWords  <= '0;
            snapErrors <= '0;
            snapLol    <= '0;
            snapDone   <= 1'b0;
        end else begin
            snapDone <= snapReq;
            if (snapReq) begin
                snapWords  <= wordCount;
                snapErrors <= errorBitCount;
                snapLol    <= lolCount;
            end
        end
    end

endmodule

// File: tb/tb_prbs7_error_accumulator.sv
// Directed bench: lock, accumulate, unlock, clamp, saturation, snapshot.
// A second instance with CNT_W=8 shares stimulus to show saturation.
module tb_prbs7_error_accumulator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [6:0]  errorCounter = 7'd0;
    logic [6:0]  usererrorCounter = 7'd0;
    logic        snapReq = 1'b0;

    logic [1:0]  state;
    logic        locked;
    logic [47:0] wordCount, errorBitCount, userErrorBitCount;
    logic [15:0] lolCount, snapLol;
    logic [47:0] snapWords, snapErrors, snapUserErrors;
    logic        snapDone;

    logic [1:0]  state8;
    logic        locked8;
    logic [7:0]  wordCount8, errorBitCount8, userErrorBitCount8;
    logic [15:0] lolCount8, snapLol8;
    logic [7:0]  snapWords8, snapErrors8, snapUserErrors8;
    logic        snapDone8;

    int total = 0;
    int bad = 0;
    logic [47:0] user_exp;

    always #5 clk = ~clk;

    prbs7_error_accumulator dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .stop              (stop),
        .errorCounter      (errorCounter),
        .usererrorCounter  (usererrorCounter),
        .snapReq           (snapReq),
        .state             (state),
        .locked            (locked),
        .wordCount         (wordCount),
        .errorBitCount     (errorBitCount),
        .userErrorBitCount (userErrorBitCount),
        .lolCount          (lolCount),
        .snapWords         (snapWords),
        .snapErrors        (snapErrors),
        .snapUserErrors    (snapUserErrors),
        .snapLol           (snapLol),
        .snapDone          (snapDone)
    );

    prbs7_error_accumulator #(.CNT_W(8)) dut8 (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .stop              (stop),
        .errorCounter      (errorCounter),
        .usererrorCounter  (usererrorCounter),
        .snapReq           (snapReq),
        .state             (state8),
        .locked            (locked8),
        .wordCount         (wordCount8),
        .errorBitCount     (errorBitCount8),
        .userErrorBitCount (userErrorBitCount8),
        .lolCount          (lolCount8),
        .snapWords         (snapWords8),
        .snapErrors        (snapErrors8),
        .snapUserErrors    (snapUserErrors8),
        .snapLol           (snapLol8),
        .snapDone          (snapDone8)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2);
        total++;
        if (state !== 2'd0 || locked !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got=%0d/%0d want=0/0", state, locked);
        end
        total++;
        if (wordCount !== 48'd0 || errorBitCount !== 48'd0 || lolCount !== 16'd0 || snapDone !== 1'b0) begin
            bad++;
            $display("FAIL reset_totals got=%0d/%0d/%0d/%0d want=0", wordCount, errorBitCount, lolCount, snapDone);
        end
        reset = 1'b0;
    endtask

    task automatic test_lock();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        total++;
        if (state !== 2'd1 || wordCount !== 48'd0) begin
            bad++;
            $display("FAIL start_settle got=%0d/%0d want=1/0", state, wordCount);
        end
        errorCounter = 7'd0;
        tick(7);
        total++;
        if (state !== 2'd1) begin
            bad++;
            $display("FAIL settle_hold got=%0d want=1", state);
        end
        tick(1);
        total++;
        if (state !== 2'd2) begin
            bad++;
            $display("FAIL settle_to_hunt got=%0d want=2", state);
        end
        tick(15);
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("FAIL lock_early got=%0d want=0", locked);
        end
        tick(1);
        total++;
        if (locked !== 1'b1 || state !== 2'd3 || wordCount !== 48'd0) begin
            bad++;
            $display("FAIL lock got=%0d/%0d/%0d want=1/3/0", locked, state, wordCount);
        end
        tick(100);
        total++;
        if (wordCount !== 48'd100 || errorBitCount !== 48'd0) begin
            bad++;
            $display("FAIL words100 got=%0d/%0d want=100/0", wordCount, errorBitCount);
        end
    endtask

    task automatic test_errors();
        errorCounter = 7'd3;
        tick(1);
        errorCounter = 7'd0;
        tick(1);
        errorCounter = 7'd5;
        tick(1);
        errorCounter = 7'd0;
        total++;
        if (errorBitCount !== 48'd8 || wordCount !== 48'd103) begin
            bad++;
            $display("FAIL err_sum got=%0d/%0d want=8/103", errorBitCount, wordCount);
        end
    endtask

    task automatic test_unlock();
        errorCounter = 7'd16;
        tick(3);
        errorCounter = 7'd15;
        tick(1);
        errorCounter = 7'd0;
        total++;
        if (locked !== 1'b1 || errorBitCount !== 48'd71 || wordCount !== 48'd107) begin
            bad++;
            $display("FAIL three_bad got=%0d/%0d/%0d want=1/71/107", locked, errorBitCount, wordCount);
        end
        errorCounter = 7'd16;
        tick(3);
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL unlock_early got=%0d want=1", locked);
        end
        tick(1);
        errorCounter = 7'd0;
        total++;
        if (locked !== 1'b0 || state !== 2'd2 || lolCount !== 16'd1) begin
            bad++;
            $display("FAIL unlock got=%0d/%0d/%0d want=0/2/1", locked, state, lolCount);
        end
        total++;
        if (errorBitCount !== 48'd135 || wordCount !== 48'd111) begin
            bad++;
            $display("FAIL unlock_totals got=%0d/%0d want=135/111", errorBitCount, wordCount);
        end
    endtask

    task automatic test_hunt_restart();
        tick(15);
        errorCounter = 7'd1;
        tick(1);
        errorCounter = 7'd0;
        tick(15);
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("FAIL relock_early got=%0d want=0", locked);
        end
        tick(1);
        total++;
        if (locked !== 1'b1 || wordCount !== 48'd111 || errorBitCount !== 48'd135) begin
            bad++;
            $display("FAIL relock got=%0d/%0d/%0d want=1/111/135", locked, wordCount, errorBitCount);
        end
    endtask

    task automatic test_clamp_sat();
        errorCounter = 7'd100;
        tick(1);
        total++;
        if (errorBitCount !== 48'd199 || errorBitCount8 !== 8'd199) begin
            bad++;
            $display("FAIL clamp got=%0d/%0d want=199/199", errorBitCount, errorBitCount8);
        end
        errorCounter = 7'd64;
        tick(2);
        errorCounter = 7'd0;
        tick(1);
        total++;
        if (errorBitCount8 !== 8'd255 || errorBitCount !== 48'd327) begin
            bad++;
            $display("FAIL saturate got=%0d/%0d want=255/327", errorBitCount8, errorBitCount);
        end
        total++;
        if (locked !== 1'b1 || wordCount !== 48'd115 || wordCount8 !== 8'd115) begin
            bad++;
            $display("FAIL sat_words got=%0d/%0d/%0d want=1/115/115", locked, wordCount, wordCount8);
        end
        errorCounter = 7'd64;
        tick(1);
        errorCounter = 7'd0;
        total++;
        if (errorBitCount8 !== 8'd255 || errorBitCount !== 48'd391) begin
            bad++;
            $display("FAIL sat_hold got=%0d/%0d want=255/391", errorBitCount8, errorBitCount);
        end
        tick(1);
    endtask

    task automatic test_snapshot();
        snapReq = 1'b1;
        errorCounter = 7'd5;
        tick(1);
        total++;
        if (snapDone !== 1'b1 || snapWords !== 48'd117 || snapErrors !== 48'd391 || snapLol !== 16'd1) begin
            bad++;
            $display("FAIL snap1 got=%0d/%0d/%0d/%0d want=1/117/391/1", snapDone, snapWords, snapErrors, snapLol);
        end
        total++;
        if (wordCount !== 48'd118 || errorBitCount !== 48'd396) begin
            bad++;
            $display("FAIL snap1_live got=%0d/%0d want=118/396", wordCount, errorBitCount);
        end
        errorCounter = 7'd0;
        tick(1);
        total++;
        if (snapDone !== 1'b1 || snapWords !== 48'd118 || snapErrors !== 48'd396) begin
            bad++;
            $display("FAIL snap2 got=%0d/%0d/%0d want=1/118/396", snapDone, snapWords, snapErrors);
        end
        snapReq = 1'b0;
        tick(1);
        total++;
        if (snapDone !== 1'b0) begin
            bad++;
            $display("FAIL snap_end got=%0d want=0", snapDone);
        end
    endtask

    task automatic test_user();
`ifdef PRBS_ERR_USER_COUNT_EN
        user_exp = 48'd20;
`else
        user_exp = 48'd0;
`endif
        usererrorCounter = 7'd2;
        tick(10);
        usererrorCounter = 7'd0;
        total++;
        if (userErrorBitCount !== user_exp || wordCount !== 48'd130) begin
            bad++;
            $display("FAIL user got=%0d/%0d want=%0d/130", userErrorBitCount, wordCount, user_exp);
        end
    endtask

    task automatic test_stop_start();
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        errorCounter = 7'd5;
        tick(2);
        errorCounter = 7'd0;
        total++;
        if (state !== 2'd0 || wordCount !== 48'd130 || errorBitCount !== 48'd396) begin
            bad++;
            $display("FAIL stop_hold got=%0d/%0d/%0d want=0/130/396", state, wordCount, errorBitCount);
        end
        start = 1'b1;
        stop = 1'b1;
        snapReq = 1'b1;
        tick(1);
        start = 1'b0;
        stop = 1'b0;
        snapReq = 1'b0;
        total++;
        if (state !== 2'd1 || wordCount !== 48'd0 || errorBitCount !== 48'd0 || lolCount !== 16'd0) begin
            bad++;
            $display("FAIL start_stop got=%0d/%0d/%0d/%0d want=1/0/0/0", state, wordCount, errorBitCount, lolCount);
        end
        total++;
        if (snapDone !== 1'b1 || snapWords !== 48'd130 || snapLol !== 16'd1) begin
            bad++;
            $display("FAIL snap_preclear got=%0d/%0d/%0d want=1/130/1", snapDone, snapWords, snapLol);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_errors();
        test_unlock();
        test_hunt_restart();
        test_clamp_sat();
        test_snapshot();
        test_user();
        test_stop_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prbs7_error_accumulator.md
# prbs7_error_accumulator

Downstream consumer of the PRBS7 checker. Takes the checker's per-clock pipelined error popcounts (`errorCounter`, `usererrorCounter`, 0..64 each), blanks the checker pipeline after start, and hunts for pattern lock. Once locked it accumulates word, bit-error and user-error totals and counts loss-of-lock events. It provides a coherent snapshot for slow register readout.

## Interface
- `CNT_W`, 48: width of word/error accumulators
- `SETTLE_CYCLES`, 8: cycles ignored after `start` (covers checker pipeline)
- `LOCK_WORDS`, 16: consecutive zero-error words required to lock
- `UNLOCK_THRESH`, 16: per-word error count at or above which a word is "bad"
- `UNLOCK_WORDS`, 4: consecutive bad words that drop lock
- `clk` in 1: single clock, one 64-bit word per cycle
- `reset` in 1: synchronous, active-high
- `start` in 1: pulse; clear totals, begin measurement
- `stop` in 1: pulse; end measurement, hold totals
- `errorCounter` in 7: checker PRBS error bits this word
- `usererrorCounter` in 7: checker user-field error bits this word
- `snapReq` in 1: pulse; capture totals
- `state` out 2: 0 IDLE, 1 SETTLE, 2 HUNT, 3 LOCKED
- `locked` out 1: `state==LOCKED`
- `wordCount` out CNT_W: words accumulated while LOCKED
- `errorBitCount` out CNT_W: saturating sum of `errorCounter` while LOCKED
- `userErrorBitCount` out CNT_W: saturating sum of `usererrorCounter` while LOCKED
- `lolCount` out 16: saturating loss-of-lock events
- `snapWords`, `snapErrors`, `snapUserErrors` out CNT_W; `snapLol` out 16: snapshot copies
- `snapDone` out 1: one-cycle pulse, snapshot valid

## Operation
- Input values >64 are clamped to 64 before use.
- IDLE: nothing accumulates. `start` → SETTLE.
- SETTLE:
  - Settle counter runs `SETTLE_CYCLES` cycles; inputs are ignored.
  - → HUNT on the cycle the counter reaches `SETTLE_CYCLES`-1.
- HUNT:
  - Good-run counter increments on `errorCounter==0` and clears on nonzero.
  - Reaching `LOCK_WORDS` → LOCKED.
  - The completing word is not accumulated.
- LOCKED, every cycle:
  - `wordCount`+1.
  - `errorBitCount`+=e and `userErrorBitCount`+=u, each saturating at all-ones. `wordCount` also saturates.
  - Bad-run counter increments when e≥`UNLOCK_THRESH` and clears otherwise.
  - Reaching `UNLOCK_WORDS` → HUNT and `lolCount`+1 (saturating). The triggering word is still accumulated. The good-run counter restarts at 0.
- `stop` from any state → IDLE; totals hold.
- `start` from any state:
  - Clears all totals, `lolCount`, and run counters.
  - → SETTLE.
  - Accumulation in that cycle is discarded.
- Priority: `reset` > `start` > `stop` > normal operation.
- Snapshot:
  - `snapReq` copies the totals as registered in that cycle, i.e. before that cycle's update.
  - The copy appears, with `snapDone`=1, on the next cycle.
  - Back-to-back `snapReq` gives back-to-back snapshots.
  - A `snapReq` coinciding with `start` captures the pre-clear values.
- The checker carries no valid signal, so every clock is one word.

## Timing
- All outputs are registered.
- Reset values: `state`=IDLE, `locked`=0, all totals/snapshots/`lolCount`=0, `snapDone`=0.
- `start` at cycle N: `state`=SETTLE and totals=0 at N+1; HUNT at N+1+`SETTLE_CYCLES`.
- Lock: the last of `LOCK_WORDS` good words sampled at cycle M gives `locked`=1 at M+1. The first accumulated word is sampled at M+1, and the totals reflect it at M+2.
- Accumulator latency is one cycle from input sample to updated total.
- Unlock: the last bad word sampled at cycle K gives `locked`=0 and `lolCount` incremented at K+1, with that word included in the totals.
- Reset mid-measurement takes effect in the next cycle, with no partial snapshot.

## Configuration
- `PRBS_ERR_USER_COUNT_EN` defined: the user-error accumulator and `snapUserErrors` are implemented.
- `PRBS_ERR_USER_COUNT_EN` undefined:
  - `usererrorCounter` is ignored.
  - `userErrorBitCount` and `snapUserErrors` are constant 0.
  - No user-error registers are synthesised.
  - All other behaviour is identical.

## Structure
- Shared package `prbs_check_pkg`: state encoding constants (IDLE/SETTLE/HUNT/LOCKED), `WORD_BITS`=64, and the input clamp value 64.
- One sub-module `sat_accum` (parameter width; inputs `clr`, `en`, increment; saturating register). It is instantiated for `wordCount`, `errorBitCount`, `userErrorBitCount`, and the 16-bit `lolCount`.
- The FSM, run counters and snapshot logic stay in the top module.

## Test plan
- Reset, then `start`, then 8 settle cycles, then 16 words of e=0 → `locked`=1 at the expected cycle. 100 further zero words → `wordCount`=100, `errorBitCount`=0.
- Locked, then words with e=3,0,5 → `errorBitCount`=8, `wordCount`+3. Inject e=1 during HUNT at run 15 → lock delayed by a full 16 further good words.
- Locked, then 4 words of e=16 → `locked`=0, `lolCount`=1, `errorBitCount` includes 64. Only 3 bad words followed by e=15 → stays locked.
- Preload near saturation with CNT_W=8 and e=64 repeatedly → `errorBitCount` holds 255. Input e=100 → counted as 64.
- `snapReq` while locked → `snapDone` the next cycle, with snap values equal to the totals of the request cycle. `start` and `stop` in the same cycle → SETTLE with cleared totals.
- With `PRBS_ERR_USER_COUNT_EN`, u=2 per locked word for 10 words → `userErrorBitCount`=20. Without the macro → 0.
